demux1_4_fifo: RTL and testbench

//   Registered 1-to-4 stream demultiplexer. It is the distribution counterpart of the team's

---
 rtl/demux1_4_fifo.sv | 104 ++++++++++
 tb/tb_demux1_4_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/demux1_4_fifo.sv
// Purpose: registered 1:4 stream demux, one 2-entry FIFO per channel, saturating drop counter.
// Latency: 1 cycle from input accept to out_valid on an empty channel; 1 word/cycle sustained.
// Backpressure: in_ready drops only when the selected enabled channel is full; disabled channels always sink.

// Two-entry FIFO slice for one channel; caller guarantees no push when full, no pop when empty.
module demux1_4_fifo_ch #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [1:0]    level
);

  logic [DW-1:0] mem0;
  logic [DW-1:0] mem1;
  logic          wr_ptr;
  logic          rd_ptr;

  // Storage, pointers and occupancy; simultaneous push/pop leaves the level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      level  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) mem1 <= push_data;
        else        mem0 <= push_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      level <= level + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = rd_ptr ? mem1 : mem0;

endmodule

module demux1_4_fifo #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_sel,
  input  logic [DW-1:0]     in_data,
  input  logic [3:0]        ch_en,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [4*DW-1:0]   out_data,
  output logic [7:0]        out_level,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic [1:0] lvl [4];
  logic       accept;
  logic       sel_en;
  logic       drop;

  // Ready looks only at the selected channel's enable and registered level, never at out_ready.
  assign sel_en   = ch_en[in_sel];
  assign in_ready = ~sel_en | (lvl[in_sel] != 2'd2);
  assign accept   = in_valid & in_ready;
  assign drop     = accept & ~sel_en;

  for (genvar k = 0; k < 4; k++) begin : g_ch
    logic push;
    logic pop;

    assign push         = accept & sel_en & (in_sel == 2'(k));
    assign out_valid[k] = (lvl[k] != 2'd0);
    assign pop          = out_valid[k] & out_ready[k];
    assign out_level[2*k +: 2] = lvl[k];

    demux1_4_fifo_ch #(.DW(DW)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (in_data),
      .pop       (pop),
      .head      (out_data[k*DW +: DW]),
      .level     (lvl[k])
    );
  end

  // Count words sunk by disabled channels, holding at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux1_4_fifo.sv
// Purpose: directed checks of demux1_4_fifo routing, backpressure, drop counting and reset.
// Latency: inputs driven 1 time unit after posedge, outputs sampled before the next edge.
// Backpressure: exercised through out_ready stalls and ch_en sinking.
module tb_demux1_4_fifo;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [7:0]  in_data;
  logic [3:0]  ch_en;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_level;
  logic [15:0] drop_cnt;

  // Second instance with a narrow counter for the saturation case.
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  s_out_valid;
  logic [31:0] s_out_data;
  logic [7:0]  s_out_level;
  logic [3:0]  s_drop_cnt;

  int n_chk;
  int n_fail;

  demux1_4_fifo #(.DW(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .ch_en     (ch_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_level (out_level),
    .drop_cnt  (drop_cnt)
  );

  demux1_4_fifo #(.DW(8), .CNT_W(4)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_valid),
    .in_ready  (s_ready),
    .in_sel    (2'd1),
    .in_data   (8'h77),
    .ch_en     (4'b0000),
    .out_valid (s_out_valid),
    .out_ready (4'b0000),
    .out_data  (s_out_data),
    .out_level (s_out_level),
    .drop_cnt  (s_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance through one rising edge and land 1 unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    #1;
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 8'h00;
    ch_en     = 4'hF;
    out_ready = 4'h0;
    s_valid   = 1'b0;

    // 1: reset state and single-word latency on channel 2
    #12;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_level", 32'(out_level), 32'h0);
    check("rst_out_data",  out_data,       32'h0);
    check("rst_drop_cnt",  32'(drop_cnt),  32'h0);
    rst_n = 1'b1;
    step();
    drive(1'b1, 2'd2, 8'hA5);
    check("t1_in_ready", 32'(in_ready), 32'h1);
    step();
    drive(1'b0, 2'd0, 8'h00);
    check("t1_out_valid", 32'(out_valid), 32'h4);
    check("t1_out_data2", 32'(out_data[23:16]), 32'hA5);
    check("t1_out_level", 32'(out_level), 32'b00_01_00_00);
    out_ready = 4'b0100;
    step();
    out_ready = 4'h0;
    check("t1_drained", 32'(out_valid), 32'h0);

    // 2: fill channel 1, stall, then drain in order while the third word enters
    drive(1'b1, 2'd1, 8'h11);
    step();
    drive(1'b1, 2'd1, 8'h22);
    step();
    drive(1'b1, 2'd1, 8'h33);
    check("t2_full_ready", 32'(in_ready), 32'h0);
    check("t2_full_level", 32'(out_level[3:2]), 32'd2);
    in_sel = 2'd3;
    #1;
    check("t2_other_ready", 32'(in_ready), 32'h1);
    drive(1'b1, 2'd1, 8'h33);
    step();
    check("t2_stall_level", 32'(out_level[3:2]), 32'd2);
    check("t2_head_11", 32'(out_data[15:8]), 32'h11);
    out_ready = 4'b0010;
    #1;
    check("t2_ready_indep", 32'(in_ready), 32'h0);
    step();
    check("t2_head_22", 32'(out_data[15:8]), 32'h22);
    check("t2_lvl_after_pop", 32'(out_level[3:2]), 32'd1);
    check("t2_ready_again", 32'(in_ready), 32'h1);
    step();
    drive(1'b0, 2'd0, 8'h00);
    check("t2_head_33", 32'(out_data[15:8]), 32'h33);
    check("t2_lvl_pushpop", 32'(out_level[3:2]), 32'd1);
    step();
    out_ready = 4'h0;
    check("t2_empty", 32'(out_valid), 32'h0);

    // 3: disabled channel 0 sinks and counts
    ch_en = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd0, 8'(8'hD0 + i));
      check("t3_ready", 32'(in_ready), 32'h1);
      step();
    end
    drive(1'b0, 2'd0, 8'h00);
    check("t3_no_valid", 32'(out_valid), 32'h0);
    check("t3_drop_cnt", 32'(drop_cnt), 32'd3);

    // 4: back-to-back streaming through channel 3
    ch_en     = 4'hF;
    out_ready = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'd3, 8'(i));
      check("t4_ready", 32'(in_ready), 32'h1);
      step();
      check("t4_valid", 32'(out_valid), 32'h8);
      check("t4_head", 32'(out_data[31:24]), 32'(i));
      check("t4_level", 32'(out_level[7:6]), 32'd1);
    end
    drive(1'b0, 2'd0, 8'h00);
    step();
    out_ready = 4'h0;
    check("t4_drained", 32'(out_level), 32'h0);

    // 5: narrow counter saturates at 15
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 13) check("t5_cnt14", 32'(s_drop_cnt), 32'd14);
    end
    s_valid = 1'b0;
    check("t5_sat", 32'(s_drop_cnt), 32'd15);
    check("t5_sat_ready", 32'(s_ready), 32'h1);
    check("t5_sat_no_valid", 32'(s_out_valid), 32'h0);

    // 6: asynchronous reset mid-cycle with channel 0 full
    ch_en = 4'b1110;
    drive(1'b1, 2'd0, 8'hE1);
    step();
    drive(1'b1, 2'd0, 8'hE2);
    step();
    ch_en = 4'hF;
    drive(1'b1, 2'd0, 8'h5A);
    step();
    drive(1'b1, 2'd0, 8'h6B);
    step();
    drive(1'b0, 2'd0, 8'h00);
    check("t6_pre_level", 32'(out_level[1:0]), 32'd2);
    check("t6_pre_drop", 32'(drop_cnt), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'h0);
    check("t6_rst_drop", 32'(drop_cnt), 32'h0);
    check("t6_rst_level", 32'(out_level), 32'h0);
    #2;
    rst_n = 1'b1;
    step();
    drive(1'b1, 2'd0, 8'hC3);
    check("t6_post_ready", 32'(in_ready), 32'h1);
    step();
    drive(1'b0, 2'd0, 8'h00);
    check("t6_post_valid", 32'(out_valid), 32'h1);
    check("t6_post_data", 32'(out_data[7:0]), 32'hC3);
    check("t6_post_level", 32'(out_level), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
